// File: rtl/quad_pkg.sv
// Shared types and constants for the quadrature emulator.
package quad_pkg;

   localparam int unsigned MIN_PHASE_DEFAULT = 64;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   // Encoding is {A, B} so the phase register drives the outputs directly.
   typedef enum logic [1:0] {
      P00 = 2'b00,
      P10 = 2'b10,
      P11 = 2'b11,
      P01 = 2'b01
   } phase_e;

   function automatic logic [15:0] clamp_len(input logic [15:0] len,
                                             input logic [15:0] min_len);
      return (len < min_len) ? min_len : len;
   endfunction

endpackage

// File: rtl/quad_emulator_if.sv
// Command / status bundle between a host and the quadrature emulator.
interface quad_emulator_if #(
   parameter int unsigned WIDTH = 16
);
   logic [WIDTH-1:0] target;
   logic             target_valid;
   logic [15:0]      phase_len;
   logic             stop;
   logic             outA;
   logic             outB;
   logic             outZ;
   logic [WIDTH-1:0] position;
   logic             busy;
   logic             dir;

   modport master (
      output target, target_valid, phase_len, stop,
      input  outA, outB, outZ, position, busy, dir
   );

   modport slave (
      input  target, target_valid, phase_len, stop,
      output outA, outB, outZ, position, busy, dir
   );
endinterface

// File: rtl/quad_phase_timer.sv
// Phase duration counter: one done pulse every len clocks once started.
module quad_phase_timer (
   input  logic        clk,
   input  logic        reset,
   input  logic        start_i,
   input  logic        halt_i,
   input  logic [15:0] len_i,
   output logic        done_o
);
   logic [15:0] len_q;
   logic [15:0] cnt_q;
   logic        run_q;

   assign done_o = run_q && (cnt_q == '0);

   // Length is captured at start and reused for every phase until the next start.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         len_q <= '0;
         cnt_q <= '0;
         run_q <= 1'b0;
      end else if (start_i) begin
         len_q <= len_i;
         cnt_q <= len_i - 16'd1;
         run_q <= 1'b1;
      end else if (halt_i) begin
         cnt_q <= '0;
         run_q <= 1'b0;
      end else if (run_q) begin
         cnt_q <= (cnt_q == '0) ? len_q - 16'd1 : cnt_q - 16'd1;
      end
   end
endmodule

// File: rtl/quad_emulator.sv
// Quadrature encoder emulator: steps A/B towards a target position, one count per 4-phase cycle.
module quad_emulator
   import quad_pkg::*;
#(
   parameter int unsigned MIN_PHASE = MIN_PHASE_DEFAULT,
   parameter int unsigned WIDTH     = 16
) (
   input logic            clk,
   input logic            reset,
   quad_emulator_if.slave bus
);
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   state_e           state_q, state_d;
   phase_e           ph_q, ph_d;
   logic [WIDTH-1:0] pos_q, pos_d;
   logic [WIDTH-1:0] tgt_q, tgt_d;
   logic             dir_q, dir_d;
   logic             z_q, z_d;
   logic             stop_q, stop_d;
   logic [WIDTH-1:0] diff;
   logic [15:0]      len_clamped;
   logic [1:0]       ab;
   logic             stop_seen;
   logic             a_rise;
   logic             tmr_start, tmr_halt, tmr_done;

   assign len_clamped = clamp_len(bus.phase_len, 16'(MIN_PHASE));
   assign diff        = tgt_q - pos_q;
   assign stop_seen   = stop_q | bus.stop;
   assign ab          = ph_q;

   assign bus.outA     = ab[1];
   assign bus.outB     = ab[0];
   assign bus.outZ     = z_q;
   assign bus.position = pos_q;
   assign bus.busy     = (state_q == RUN);
   assign bus.dir      = dir_q;

   quad_phase_timer u_timer (
      .clk     (clk),
      .reset   (reset),
      .start_i (tmr_start),
      .halt_i  (tmr_halt),
      .len_i   (len_clamped),
      .done_o  (tmr_done)
   );

   // State and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         ph_q    <= P00;
         pos_q   <= '0;
         tgt_q   <= '0;
         dir_q   <= 1'b0;
         z_q     <= 1'b0;
         stop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ph_q    <= ph_d;
         pos_q   <= pos_d;
         tgt_q   <= tgt_d;
         dir_q   <= dir_d;
         z_q     <= z_d;
         stop_q  <= stop_d;
      end
   end

   // Next-state: cycle start decisions, phase stepping, counting on A rising.
   always_comb begin
      state_d   = state_q;
      ph_d      = ph_q;
      pos_d     = pos_q;
      tgt_d     = tgt_q;
      dir_d     = dir_q;
      z_d       = z_q;
      stop_d    = stop_q | bus.stop;
      a_rise    = 1'b0;
      tmr_start = 1'b0;
      tmr_halt  = 1'b0;

      if (bus.target_valid) tgt_d = bus.target;

      unique case (state_q)
         IDLE: begin
            if (stop_seen) begin
               tgt_d  = pos_q;
               stop_d = 1'b0;
            end else if (pos_q != tgt_q) begin
               state_d   = RUN;
               dir_d     = diff[WIDTH-1];
               tmr_start = 1'b1;
            end
         end
         RUN: begin
            if (tmr_done) begin
               unique case (ph_q)
                  P00: if (dir_q) ph_d = P01; else begin ph_d = P10; a_rise = 1'b1; end
                  P10: if (dir_q) ph_d = P00; else ph_d = P11;
                  P11: if (dir_q) ph_d = P10; else ph_d = P01;
                  P01: if (dir_q) begin ph_d = P11; a_rise = 1'b1; end else ph_d = P00;
               endcase
               if (a_rise) begin
                  pos_d = dir_q ? pos_q - ONE : pos_q + ONE;
                  if (pos_d == '0) z_d = 1'b1;
               end
               // Back at AB=00: either finish (target reached or stop) or start the next cycle.
               if (ph_d == P00) begin
                  z_d = 1'b0;
                  if (stop_seen || (pos_q == tgt_q)) begin
                     state_d  = IDLE;
                     tmr_halt = 1'b1;
                     stop_d   = 1'b0;
                     if (stop_seen) tgt_d = pos_q;
                  end else begin
                     dir_d     = diff[WIDTH-1];
                     tmr_start = 1'b1;
                  end
               end
            end
         end
      endcase
   end
endmodule

// File: tb/tb_quad_emulator.sv
// Self-checking bench for quad_emulator: table-driven moves, directed corners, random moves.
module tb_quad_emulator;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   quad_emulator_if #(.WIDTH(16)) bus ();

   quad_emulator #(.MIN_PHASE(64), .WIDTH(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   function automatic void check(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
      end
   endfunction

   // Receiver model: counts A rising edges, down when B high; logs phase lengths and AB sequence.
   int          cyc = 0;
   int          seg_mark = 0;
   int          edges = 0;
   int          seg_q[$];
   int          ab_q[$];
   logic [1:0]  ab_prev = 2'b00;
   logic        busy_prev = 1'b0;
   logic [15:0] enc = '0;

   always @(negedge clk) begin
      logic [1:0] ab;
      cyc++;
      ab = {bus.outA, bus.outB};
      if (reset) begin
         enc       = '0;
         ab_prev   = 2'b00;
         busy_prev = 1'b0;
      end else begin
         if (bus.busy && !busy_prev) seg_mark = cyc;
         if (ab != ab_prev) begin
            edges++;
            seg_q.push_back(cyc - seg_mark);
            seg_mark = cyc;
            ab_q.push_back(int'(ab));
            check("gray_step", $countones(ab ^ ab_prev), 1);
            if (!ab_prev[1] && ab[1]) begin
               enc = ab[0] ? enc - 16'd1 : enc + 16'd1;
               check("pos_at_A_rise", int'(bus.position), int'(enc));
               check("z_at_A_rise", int'(bus.outZ), int'(enc == 16'd0));
            end
            if (ab == 2'b00) check("z_at_00", int'(bus.outZ), 0);
         end
         ab_prev   = ab;
         busy_prev = bus.busy;
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic start_move(input logic [15:0] tgt, input logic [15:0] pl);
      bus.target       = tgt;
      bus.phase_len    = pl;
      bus.target_valid = 1'b1;
      tick();
      bus.target_valid = 1'b0;
   endtask

   task automatic wait_busy();
      int n;
      n = 0;
      while (!bus.busy && n < 10) begin tick(); n++; end
      check("busy_rise", int'(bus.busy), 1);
   endtask

   task automatic wait_fall(input int limit);
      int n;
      n = 0;
      while (bus.busy && n < limit) begin tick(); n++; end
      check("busy_fall", int'(bus.busy), 0);
   endtask

   task automatic wait_idle(output int dur, output bit zs, output bit dr);
      dur = 0;
      zs  = 1'b0;
      wait_busy();
      dr = bus.dir;
      while (bus.busy && dur < 40000) begin
         zs |= bus.outZ;
         dur++;
         tick();
      end
      check("busy_fall", int'(bus.busy), 0);
   endtask

   task automatic check_quiet(input string nm, input int n);
      int e0;
      bit b;
      e0 = edges;
      b  = 1'b0;
      repeat (n) begin tick(); b |= bus.busy; end
      check({nm, "_edges"}, edges - e0, 0);
      check({nm, "_busy"}, int'(b), 0);
   endtask

   typedef struct {
      logic [15:0] tgt;
      logic [15:0] pl;
      logic [15:0] pos;
      bit          dir;
      int          cyc;
      bit          z;
   } vec_t;

   vec_t tbl[5];

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int          d, n, L;
      bit          zs, dr;
      logic [15:0] model_pos;

      tbl[0] = '{16'h0003, 16'd64, 16'h0003, 1'b0, 3, 1'b0};
      tbl[1] = '{16'hFFFE, 16'd64, 16'hFFFE, 1'b1, 5, 1'b1};
      tbl[2] = '{16'h0002, 16'd10, 16'h0002, 1'b0, 4, 1'b1};
      tbl[3] = '{16'h0002, 16'd80, 16'h0002, 1'b0, 0, 1'b0};
      tbl[4] = '{16'h0000, 16'd70, 16'h0000, 1'b1, 2, 1'b1};

      bus.target       = '0;
      bus.target_valid = 1'b0;
      bus.phase_len    = 16'd64;
      bus.stop         = 1'b0;

      // Reset state
      tick();
      check("rst_A", int'(bus.outA), 0);
      check("rst_B", int'(bus.outB), 0);
      check("rst_Z", int'(bus.outZ), 0);
      check("rst_pos", int'(bus.position), 0);
      check("rst_busy", int'(bus.busy), 0);
      check("rst_dir", int'(bus.dir), 0);
      tick();
      reset = 1'b0;
      check_quiet("after_reset", 300);

      // Table-driven moves
      for (int i = 0; i < 5; i++) begin
         L = (tbl[i].pl < 16'd64) ? 64 : int'(tbl[i].pl);
         seg_q.delete();
         ab_q.delete();
         start_move(tbl[i].tgt, tbl[i].pl);
         if (tbl[i].cyc == 0) begin
            check_quiet("tbl_nomove", 50);
         end else begin
            wait_idle(d, zs, dr);
            check("tbl_dur", d, tbl[i].cyc * 4 * L);
            check("tbl_dir", int'(dr), int'(tbl[i].dir));
            check("tbl_z", int'(zs), int'(tbl[i].z));
            check("tbl_nseg", seg_q.size(), 4 * tbl[i].cyc);
            foreach (seg_q[k]) check("tbl_seg", seg_q[k], L);
            if (ab_q.size() > 0) check("tbl_first_ab", ab_q[0], tbl[i].dir ? 1 : 2);
         end
         check("tbl_pos", int'(bus.position), int'(tbl[i].pos));
         check("tbl_enc", int'(enc), int'(tbl[i].pos));
      end

      // diff = 0x8000 is a down move; abort it after the first phase
      start_move(16'h8000, 16'd64);
      wait_busy();
      check("half_dir", int'(bus.dir), 1);
      n = 0;
      while (!bus.outA && !bus.outB && n < 300) begin tick(); n++; end
      check("half_first_ab", int'({bus.outA, bus.outB}), 1);
      bus.stop = 1'b1;
      tick();
      bus.stop = 1'b0;
      wait_fall(1000);
      check("half_pos", int'(bus.position), 16'hFFFF);
      check_quiet("half_stop", 400);

      // Asynchronous reset while AB=11
      start_move(16'h0002, 16'd64);
      n = 0;
      while (!(bus.outA && bus.outB) && n < 1000) begin tick(); n++; end
      check("areset_ab11", int'({bus.outA, bus.outB}), 3);
      #1;
      reset = 1'b1;
      #1;
      check("areset_A", int'(bus.outA), 0);
      check("areset_B", int'(bus.outB), 0);
      check("areset_Z", int'(bus.outZ), 0);
      check("areset_pos", int'(bus.position), 0);
      check("areset_busy", int'(bus.busy), 0);
      check("areset_dir", int'(bus.dir), 0);
      repeat (3) tick();
      reset = 1'b0;
      check_quiet("areset_quiet", 400);

      // Stop mid-cycle at position 5 while heading to 100
      seg_q.delete();
      start_move(16'd100, 16'd64);
      wait_busy();
      n = 0;
      while (bus.position != 16'd5 && n < 3000) begin tick(); n++; end
      check("stop_reach5", int'(bus.position), 5);
      repeat (30) tick();
      bus.stop = 1'b1;
      tick();
      bus.stop = 1'b0;
      wait_fall(1000);
      check("stop_pos", int'(bus.position), 5);
      check("stop_enc", int'(enc), 5);
      check("stop_nseg", seg_q.size(), 20);
      check_quiet("stop_quiet", 600);
      check("stop_pos_hold", int'(bus.position), 5);

      // phase_len changed mid-cycle only applies from the next AB=00
      seg_q.delete();
      start_move(16'd7, 16'd100);
      wait_busy();
      repeat (50) tick();
      bus.phase_len = 16'd200;
      wait_fall(3000);
      check("plchg_nseg", seg_q.size(), 8);
      foreach (seg_q[k]) check("plchg_seg", seg_q[k], (k < 4) ? 100 : 200);
      check("plchg_pos", int'(bus.position), 7);

      // target_valid and stop together: stop wins
      start_move(16'd20, 16'd64);
      wait_busy();
      repeat (40) tick();
      bus.target       = 16'd50;
      bus.target_valid = 1'b1;
      bus.stop         = 1'b1;
      tick();
      bus.target_valid = 1'b0;
      bus.stop         = 1'b0;
      wait_fall(1000);
      check("coin_pos", int'(bus.position), 8);
      check_quiet("coin_quiet", 600);

      // Random moves against a distance/direction model
      model_pos = 16'd8;
      for (int i = 0; i < 12; i++) begin
         int          off, absoff;
         logic [15:0] pl, tgt, p;
         bit          zexp;
         off    = int'($urandom_range(12, 0)) - 6;
         absoff = (off < 0) ? -off : off;
         pl     = 16'($urandom_range(100, 0));
         tgt    = model_pos + 16'(off);
         L      = (pl < 16'd64) ? 64 : int'(pl);
         zexp   = 1'b0;
         p      = model_pos;
         for (int k = 0; k < absoff; k++) begin
            p = (off < 0) ? p - 16'd1 : p + 16'd1;
            if (p == 16'd0) zexp = 1'b1;
         end
         start_move(tgt, pl);
         if (absoff == 0) begin
            check_quiet("rnd_nomove", 20);
         end else begin
            wait_idle(d, zs, dr);
            check("rnd_dur", d, absoff * 4 * L);
            check("rnd_dir", int'(dr), int'(off < 0));
            check("rnd_z", int'(zs), int'(zexp));
         end
         model_pos = tgt;
         check("rnd_pos", int'(bus.position), int'(model_pos));
         check("rnd_enc", int'(enc), int'(model_pos));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/quad_emulator.md
QUAD_EMULATOR -- requirements
Module: quad_emulator

Interface
REQ-001 The block SHALL have parameter MIN_PHASE, default 64: the minimum clk cycles per quadrature phase (above the 50-cycle debounce length).
REQ-002 The block SHALL have parameter WIDTH, default 16: the width of the position and target values.
REQ-003 clk  input  1  system clock; the single clock of the block.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 target  input  WIDTH  requested position.
REQ-006 target_valid  input  1  one-cycle strobe that loads target.
REQ-007 phase_len  input  16  clk cycles per phase; values below MIN_PHASE are treated as MIN_PHASE.
REQ-008 stop  input  1  abort motion at the next cycle boundary.
REQ-009 outA, outB  output  1 each  quadrature outputs.
REQ-010 outZ  output  1  index pulse.
REQ-011 position  output  WIDTH  emitted count.
REQ-012 busy  output  1  motion in progress.
REQ-013 dir  output  1  0 = up (A leads B), 1 = down (B leads A).

Function
REQ-014 One count SHALL equal one full 4-phase quadrature cycle.
- Up sequence (AB): 00->10->11->01->00.
- Down sequence (AB): 00->01->11->10->00.
REQ-015 position SHALL update on the clk edge where outA rises: +1 when up (outB=0), -1 when down (outB=1). This matches a receiver that counts A rising edges and decrements when B is high.
REQ-016 Each phase SHALL last exactly max(phase_len, MIN_PHASE) clk cycles; phase_len SHALL be sampled only at quadrature cycle start (AB=00).
REQ-017 The FSM SHALL have two states, IDLE and RUN.
- IDLE->RUN: at AB=00 when position != registered target and stop=0.
- RUN->IDLE: on return to AB=00 when position == target or stop was seen during the cycle.
REQ-018 Direction SHALL be decided at each cycle start from diff = target - position (mod 2^WIDTH).
- diff[WIDTH-1]=0 selects up; otherwise down.
- diff=0x8000 is therefore down.
- dir SHALL hold constant for the whole cycle.
REQ-019 position SHALL wrap modulo 2^WIDTH: 0xFFFF+1=0x0000 and 0x0000-1=0xFFFF.
REQ-020 target_valid SHALL be accepted in any state; the new target SHALL take effect at the next cycle start and never alter the cycle in progress.
REQ-021 stop SHALL be latched. The current cycle completes to AB=00, then the block SHALL set target := position, enter IDLE and clear the latch.
REQ-022 If target_valid and stop coincide, stop SHALL win: the target is still loaded, then overwritten by REQ-021.
REQ-023 outZ SHALL rise on the same edge that makes position 0 and fall when AB next returns to 00, in either direction.
REQ-024 busy SHALL be 1 in RUN and 0 in IDLE; busy SHALL fall on the same edge AB returns to 00 at the final count.
REQ-025 All outputs SHALL be registered (glitch-free) and change only on clk edges.

Reset
REQ-026 Asserting reset SHALL immediately force the following, even mid-cycle:
- outA=outB=outZ=0
- position=0, target register=0
- busy=0, dir=0
- state=IDLE, phase timer=0, stop latch=0
REQ-027 After reset deassertion the block SHALL produce no edges until a target_valid with target != 0 is received.

Structure
REQ-028 Package quad_pkg SHALL hold:
- the state enum (IDLE, RUN)
- the 2-bit phase enum (P00, P10, P11, P01)
- the default MIN_PHASE constant
REQ-029 The phase-duration counter SHALL be one sub-module, quad_phase_timer. It takes a start pulse and a clamped length, and emits a one-cycle done pulse per phase.

Verification
REQ-030 The bench SHALL cover these directed scenarios:
- Reset, then target=3, phase_len=64 -> 3 up cycles, A leads B, each phase 64 clks; position steps 1,2,3; busy falls 768 clks after start; outZ stays 0.
- position=3, target=0xFFFE -> 5 down cycles (B leads A), position 2,1,0,0xFFFF,0xFFFE; outZ high for exactly the cycle where position becomes 0.
- phase_len=10 -> phases last 64 clks (clamp); phase_len changed mid-cycle -> takes effect only at the next AB=00.
- Target=100, stop pulsed mid-cycle at position 5 -> cycle completes, position=5, busy=0, no further edges.
- Loop outA/outB/outZ into the existing encoder block; random targets -> encoder count equals position after each move, including across 0.
- reset asserted while AB=11 -> all outputs 0 asynchronously, before the next clk edge.
